// File: rtl/fp_mult_pipe.sv
// fp_mult_pipe: pipelined floating-point multiplier, format {sign, exp, frac}.
// An operand register feeds three compute stages: unpack/multiply,
// normalise/round, then saturate/flush/pack into the output register.
// exp==0 encodes zero (denormals flushed); there is no Inf/NaN encoding.
// The whole pipeline advances together whenever the output slot is free or
// being drained, so results leave in acceptance order.
module fp_mult_pipe #(
  parameter  int EXP_W    = 4,
  parameter  int FRAC_W   = 11,
  parameter  int RND_MODE = 1,
  localparam int W        = 1 + EXP_W + FRAC_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] op1,
  input  logic [W-1:0] op2,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         ovf,
  output logic         unf,
  output logic         inexact
);

  localparam int MW  = FRAC_W + 1;
  localparam int PW  = 2 * MW;
  localparam int EW2 = EXP_W + 2;

  localparam logic signed [EW2-1:0] BIAS = {3'b000, {(EXP_W-1){1'b1}}};
  localparam logic signed [EW2-1:0] EMAX = {2'b00, {EXP_W{1'b1}}};
  localparam logic signed [EW2-1:0] ONE  = {{(EW2-1){1'b0}}, 1'b1};

  // Round-up decision from guard, sticky and the kept lsb.
  function automatic logic round_inc(input logic g, input logic s, input logic lsb);
    if (RND_MODE == 1) return g & (s | lsb);
    else               return 1'b0;
  endfunction

  // Final packing: zero operand wins, then overflow saturation, then
  // underflow flush, else the normal packed word. Returns {word, ovf, unf, inexact}.
  function automatic logic [W+2:0] pack_result(
    input logic                  sign,
    input logic signed [EW2-1:0] e,
    input logic [FRAC_W-1:0]     f,
    input logic                  zero,
    input logic                  inx
  );
    if (zero)          return {sign, {(W-1){1'b0}}, 3'b000};
    else if (e > EMAX) return {sign, {(W-1){1'b1}}, 3'b101};
    else if (e < ONE)  return {sign, {(W-1){1'b0}}, 3'b011};
    else               return {sign, e[EXP_W-1:0], f, 2'b00, inx};
  endfunction

  logic en;
  assign en       = !out_valid | out_ready;
  assign in_ready = en;

  logic vld_p0, vld_p1, vld_p2;

  // Valid bits and the output register; these are cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0    <= 1'b0;
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      out_valid <= 1'b0;
    end else if (en) begin
      vld_p0    <= in_valid;
      vld_p1    <= vld_p0;
      vld_p2    <= vld_p1;
      out_valid <= vld_p2;
    end
  end

  // ---------------- operand register ----------------
  logic [W-1:0] a_p0, b_p0;

  // Capture operands whenever the pipeline advances.
  always_ff @(posedge clk) begin
    if (en) begin
      a_p0 <= op1;
      b_p0 <= op2;
    end
  end

  // ---------------- stage 1: unpack, multiply, add exponents ----------------
  logic                  s1_sign;
  logic                  s1_zero;
  logic [PW-1:0]         s1_prod;
  logic signed [EW2-1:0] s1_exp;

  // Mantissa product with hidden bits, and biased exponent sum.
  always_comb begin
    s1_sign = a_p0[W-1] ^ b_p0[W-1];
    s1_zero = (a_p0[W-2:FRAC_W] == '0) || (b_p0[W-2:FRAC_W] == '0);
    s1_prod = {{MW{1'b0}}, 1'b1, a_p0[FRAC_W-1:0]} *
              {{MW{1'b0}}, 1'b1, b_p0[FRAC_W-1:0]};
    s1_exp  = $signed({2'b00, a_p0[W-2:FRAC_W]}) +
              $signed({2'b00, b_p0[W-2:FRAC_W]}) - BIAS;
  end

  logic                  sign_p1, zero_p1;
  logic [PW-1:0]         prod_p1;
  logic signed [EW2-1:0] exp_p1;

  // Stage 1 to stage 2 register.
  always_ff @(posedge clk) begin
    if (en) begin
      sign_p1 <= s1_sign;
      zero_p1 <= s1_zero;
      prod_p1 <= s1_prod;
      exp_p1  <= s1_exp;
    end
  end

  // ---------------- stage 2: normalise and round ----------------
  logic [FRAC_W-1:0]     s2_frac_t, s2_frac;
  logic                  s2_g, s2_s, s2_carry;
  logic signed [EW2-1:0] s2_exp_n, s2_exp;

  // Product lies in [1,4); a set MSB means one extra binary place.
  always_comb begin
    if (prod_p1[PW-1]) begin
      s2_frac_t = prod_p1[PW-2 -: FRAC_W];
      s2_g      = prod_p1[FRAC_W];
      s2_s      = |prod_p1[FRAC_W-1:0];
      s2_exp_n  = exp_p1 + ONE;
    end else begin
      s2_frac_t = prod_p1[PW-3 -: FRAC_W];
      s2_g      = prod_p1[FRAC_W-1];
      s2_s      = |prod_p1[FRAC_W-2:0];
      s2_exp_n  = exp_p1;
    end
    {s2_carry, s2_frac} = {1'b0, s2_frac_t} +
                          {{FRAC_W{1'b0}}, round_inc(s2_g, s2_s, s2_frac_t[0])};
    // A carry out of an all-ones fraction leaves frac==0 and bumps the exponent.
    s2_exp = s2_carry ? (s2_exp_n + ONE) : s2_exp_n;
  end

  logic                  sign_p2, zero_p2, inx_p2;
  logic [FRAC_W-1:0]     frac_p2;
  logic signed [EW2-1:0] exp_p2;

  // Stage 2 to stage 3 register.
  always_ff @(posedge clk) begin
    if (en) begin
      sign_p2 <= sign_p1;
      zero_p2 <= zero_p1;
      inx_p2  <= s2_g | s2_s;
      frac_p2 <= s2_frac;
      exp_p2  <= s2_exp;
    end
  end

  // ---------------- stage 3: saturate, flush, pack ----------------
  logic [W+2:0] s3_pack;

  // Range resolution of the rounded exponent.
  always_comb begin
    s3_pack = pack_result(sign_p2, exp_p2, frac_p2, zero_p2, inx_p2);
  end

  // Output register; held while a result waits for the consumer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result  <= '0;
      ovf     <= 1'b0;
      unf     <= 1'b0;
      inexact <= 1'b0;
    end else if (en) begin
      result  <= s3_pack[W+2:3];
      ovf     <= s3_pack[2];
      unf     <= s3_pack[1];
      inexact <= s3_pack[0];
    end
  end

endmodule

// File: tb/tb_fp_mult_pipe.sv
// Bench for fp_mult_pipe: three instances share one handshake; two 16-bit
// copies (round-to-nearest-even and truncate) and one 32-bit copy.
module tb_fp_mult_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [15:0] op1_a = '0, op2_a = '0;
  logic [31:0] op1_c = '0, op2_c = '0;

  logic in_ready_a, out_valid_a, ovf_a, unf_a, inexact_a;
  logic in_ready_b, out_valid_b, ovf_b, unf_b, inexact_b;
  logic in_ready_c, out_valid_c, ovf_c, unf_c, inexact_c;
  logic [15:0] result_a, result_b;
  logic [31:0] result_c;

  fp_mult_pipe #(.EXP_W(4), .FRAC_W(11), .RND_MODE(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .op1(op1_a), .op2(op2_a), .out_valid(out_valid_a), .out_ready(out_ready),
    .result(result_a), .ovf(ovf_a), .unf(unf_a), .inexact(inexact_a));

  fp_mult_pipe #(.EXP_W(4), .FRAC_W(11), .RND_MODE(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .op1(op1_a), .op2(op2_a), .out_valid(out_valid_b), .out_ready(out_ready),
    .result(result_b), .ovf(ovf_b), .unf(unf_b), .inexact(inexact_b));

  fp_mult_pipe #(.EXP_W(8), .FRAC_W(23), .RND_MODE(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_c),
    .op1(op1_c), .op2(op2_c), .out_valid(out_valid_c), .out_ready(out_ready),
    .result(result_c), .ovf(ovf_c), .unf(unf_c), .inexact(inexact_c));

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a, b, rne; logic [2:0] frne;
    logic [15:0] trn;       logic [2:0] ftrn;
    logic [31:0] c, d, r32; logic [2:0] f32;
  } vec_t;
  vec_t tab [9];

  int total = 0, bad = 0, cyc = 0, obs = 0;
  logic [18:0] exp_a[$], exp_b[$];
  logic [34:0] exp_c[$];
  int acc_q[$];
  int lat [0:4095];
  int pc  [0:4095];
  logic stall_prev = 1'b0;
  logic [18:0] held_a;
  logic [34:0] held_c;
  logic done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic fail(input string nm);
    total++; bad++;
    $display("FAIL %s", nm);
  endtask

  task automatic check(input string nm, input logic [34:0] got, input logic [34:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h (t=%0t)", nm, got, want, $time);
    end
  endtask

  task automatic check_int(input string nm, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  // Reference: value-level multiply with integer mantissas and explicit rounding.
  function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input int ew, input int fw, input int rnd);
    longint unsigned ma, mb, prod, q, rem, half, res;
    int ea, eb, e, sh, w;
    logic s, o, u, x;
    w = 1 + ew + fw;
    s = a[w-1] ^ b[w-1];
    ea = int'((a >> fw) & ((32'd1 << ew) - 1));
    eb = int'((b >> fw) & ((32'd1 << ew) - 1));
    o = 1'b0; u = 1'b0; x = 1'b0;
    if (ea == 0 || eb == 0) begin
      res = longint'(s) << (w - 1);
    end else begin
      ma = (64'd1 << fw) + (a & ((64'd1 << fw) - 1));
      mb = (64'd1 << fw) + (b & ((64'd1 << fw) - 1));
      prod = ma * mb;
      e = ea + eb - ((1 << (ew - 1)) - 1);
      if (prod >= (64'd1 << (2 * fw + 1))) begin sh = fw + 1; e++; end
      else sh = fw;
      q = prod >> sh;
      rem = prod - (q << sh);
      half = 64'd1 << (sh - 1);
      x = (rem != 0);
      if (rnd != 0 && (rem > half || (rem == half && q[0]))) q++;
      if (q == (64'd1 << (fw + 1))) begin q = q >> 1; e++; end
      if (e > (1 << ew) - 1) begin
        o = 1'b1; x = 1'b1;
        res = (longint'(s) << (w - 1)) | ((64'd1 << (w - 1)) - 1);
      end else if (e < 1) begin
        u = 1'b1; x = 1'b1;
        res = longint'(s) << (w - 1);
      end else begin
        res = (longint'(s) << (w - 1)) | (longint'(e) << fw) | (q - (64'd1 << fw));
      end
    end
    return {res[31:0], o, u, x};
  endfunction

  function automatic logic [15:0] rnd16();
    if ($urandom_range(1) == 1) return 16'($urandom);
    return {1'($urandom), 4'($urandom_range(4, 10)), 11'($urandom)};
  endfunction

  function automatic logic [31:0] rnd32();
    if ($urandom_range(1) == 1) return $urandom;
    return {1'($urandom), 8'($urandom_range(90, 165)), 23'($urandom)};
  endfunction

  // Output monitor: scoreboard, stall behaviour and instance agreement.
  always @(negedge clk) begin
    if (rst_n) begin
      check("valid_sync", {33'd0, out_valid_b, out_valid_c}, {33'd0, out_valid_a, out_valid_a});
      if (out_valid_a && !out_ready) begin
        check("in_ready_stall", {34'd0, in_ready_a}, 35'd0);
        if (stall_prev) begin
          check("hold_a", {16'd0, result_a, ovf_a, unf_a, inexact_a}, {16'd0, held_a});
          check("hold_c", {result_c, ovf_c, unf_c, inexact_c}, held_c);
        end
        stall_prev = 1'b1;
        held_a = {result_a, ovf_a, unf_a, inexact_a};
        held_c = {result_c, ovf_c, unf_c, inexact_c};
      end else begin
        stall_prev = 1'b0;
      end
      if (out_valid_a && out_ready) begin
        if (exp_a.size() == 0) begin
          fail("unexpected_output");
        end else begin
          check("res16_rne", {16'd0, result_a, ovf_a, unf_a, inexact_a}, {16'd0, exp_a.pop_front()});
          check("res16_trn", {16'd0, result_b, ovf_b, unf_b, inexact_b}, {16'd0, exp_b.pop_front()});
          check("res32_rne", {result_c, ovf_c, unf_c, inexact_c}, exp_c.pop_front());
        end
        if (obs < 4096) begin
          lat[obs] = (acc_q.size() != 0) ? cyc - acc_q.pop_front() : -1;
          pc[obs] = cyc;
        end
        obs++;
      end
    end
  end

  // Offer one operand set until accepted; returns at posedge+1 after acceptance.
  task automatic xfer(input logic [15:0] a, input logic [15:0] b,
                      input logic [31:0] c, input logic [31:0] d,
                      input logic [18:0] xa, input logic [18:0] xb, input logic [34:0] xc);
    int n;
    n = 0;
    op1_a = a; op2_a = b; op1_c = c; op2_c = d; in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready_a) begin
        exp_a.push_back(xa); exp_b.push_back(xb); exp_c.push_back(xc);
        acc_q.push_back(cyc + 1);
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
      n++;
      if (n > 100) begin
        fail("accept_timeout");
        in_valid = 1'b0;
        break;
      end
    end
  endtask

  task automatic xfer_rand();
    logic [15:0] a, b;
    logic [31:0] c, d;
    logic [34:0] ma, mb, mc;
    a = rnd16(); b = rnd16(); c = rnd32(); d = rnd32();
    ma = model({16'd0, a}, {16'd0, b}, 4, 11, 1);
    mb = model({16'd0, a}, {16'd0, b}, 4, 11, 0);
    mc = model(c, d, 8, 23, 1);
    xfer(a, b, c, d, ma[18:0], mb[18:0], mc);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_a.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    check_int("drain_empty", exp_a.size(), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int obs0, n;
    tab[0] = '{16'h3C00, 16'h3C00, 16'h4100, 3'b000, 16'h4100, 3'b000, 32'h3FC00000, 32'h3FC00000, 32'h40100000, 3'b000};
    tab[1] = '{16'h3800, 16'hC000, 16'hC000, 3'b000, 16'hC000, 3'b000, 32'h3F800000, 32'hC0000000, 32'hC0000000, 3'b000};
    tab[2] = '{16'h3801, 16'h3C00, 16'h3C02, 3'b001, 16'h3C01, 3'b001, 32'h3F800001, 32'h3FC00000, 32'h3FC00002, 3'b001};
    tab[3] = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 3'b101, 16'h7FFF, 3'b101, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 3'b101};
    tab[4] = '{16'h0800, 16'h0800, 16'h0000, 3'b011, 16'h0000, 3'b011, 32'h00800000, 32'h00800000, 32'h00000000, 3'b011};
    tab[5] = '{16'h8800, 16'h0800, 16'h8000, 3'b011, 16'h8000, 3'b011, 32'h80800000, 32'h00800000, 32'h80000000, 3'b011};
    tab[6] = '{16'h0000, 16'h3C00, 16'h0000, 3'b000, 16'h0000, 3'b000, 32'h00000000, 32'h3FC00000, 32'h00000000, 3'b000};
    tab[7] = '{16'h8000, 16'h3800, 16'h8000, 3'b000, 16'h8000, 3'b000, 32'h80000000, 32'h3F800000, 32'h80000000, 3'b000};
    tab[8] = '{16'h3FFE, 16'h3801, 16'h4000, 3'b001, 16'h3FFF, 3'b001, 32'h3F800000, 32'h3F800000, 32'h3F800000, 3'b000};

    // Reset state.
    #12;
    check("rst_out_valid_a", {34'd0, out_valid_a}, 35'd0);
    check("rst_out_valid_c", {34'd0, out_valid_c}, 35'd0);
    check("rst_result_a", {16'd0, result_a, ovf_a, unf_a, inexact_a}, 35'd0);
    check("rst_result_c", {result_c, ovf_c, unf_c, inexact_c}, 35'd0);
    check("rst_in_ready", {34'd0, in_ready_a}, 35'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;

    // Directed vectors, one at a time through an empty pipeline.
    for (int i = 0; i < 9; i++) begin
      xfer(tab[i].a, tab[i].b, tab[i].c, tab[i].d,
           {tab[i].rne, tab[i].frne}, {tab[i].trn, tab[i].ftrn}, {tab[i].r32, tab[i].f32});
      in_valid = 1'b0;
      drain();
      if (obs > 0) check_int("latency", lat[obs-1], 3);
      else fail("latency_no_output");
    end

    // Back-to-back stream of 6 with the consumer stalled for 5 cycles.
    obs0 = obs;
    fork
      begin
        for (int i = 0; i < 6; i++) xfer_rand();
        in_valid = 1'b0;
      end
      begin
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    check_int("bp_count", obs - obs0, 6);

    // Full-rate streaming: one result per cycle.
    obs0 = obs;
    for (int i = 0; i < 12; i++) xfer_rand();
    in_valid = 1'b0;
    drain();
    check_int("stream_count", obs - obs0, 12);
    if (obs - obs0 == 12) check_int("stream_rate", pc[obs0 + 11] - pc[obs0], 11);

    // Reset while two operations are in flight and the first is stalled at the output.
    out_ready = 1'b0;
    xfer_rand();
    xfer_rand();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid_a && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("mid_out_valid_up", {34'd0, out_valid_a}, 35'd1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_valid_a", {34'd0, out_valid_a}, 35'd0);
    check("mid_rst_valid_c", {34'd0, out_valid_c}, 35'd0);
    check("mid_rst_result", {16'd0, result_a, ovf_a, unf_a, inexact_a}, 35'd0);
    check("mid_rst_in_ready", {34'd0, in_ready_a}, 35'd1);
    exp_a.delete(); exp_b.delete(); exp_c.delete(); acc_q.delete();
    stall_prev = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    obs0 = obs;
    repeat (6) @(posedge clk);
    #1;
    check_int("mid_no_ghost", obs - obs0, 0);
    xfer_rand();
    in_valid = 1'b0;
    drain();
    check_int("mid_post_count", obs - obs0, 1);
    if (obs > obs0) check_int("mid_post_latency", lat[obs-1], 3);

    // Randomised traffic with random gaps and random backpressure.
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(3) == 0) begin
            in_valid = 1'b0;
            repeat ($urandom_range(1, 2)) @(posedge clk);
            #1;
          end
          xfer_rand();
        end
        in_valid = 1'b0;
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
